// File: rtl/ofdm_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ofdm_tx_pkg                                                              |
// | Shared types and constants for the 802.11a/g legacy OFDM transmit bit    |
// | framer: framer state encoding, RATE -> N_DBPS lookup, CRC-32 constants   |
// | and the fixed field lengths of the PPDU.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ofdm_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SIG     = 3'd1,
      ST_SERVICE = 3'd2,
      ST_PSDU    = 3'd3,
      ST_FCS     = 3'd4,
      ST_TAIL    = 3'd5,
      ST_PAD     = 3'd6
   } state_e;

   localparam logic [31:0] c_crc_poly = 32'hEDB88320;   // reflected CRC-32
   localparam logic [31:0] c_crc_init = 32'hFFFFFFFF;

   localparam int c_sig_bits     = 24;
   localparam int c_service_bits = 16;
   localparam int c_fcs_bits     = 32;
   localparam int c_tail_bits    = 6;
   localparam int c_fcs_bytes    = 4;

   localparam logic [6:0] c_scram_default_seed = 7'h5D;

   // Data bits per OFDM symbol for each legal L-SIG RATE code; 0 flags an
   // illegal code.
   function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
      logic [7:0] n;
      case (rate)
         4'hB:    n = 8'd24;
         4'hF:    n = 8'd36;
         4'hA:    n = 8'd48;
         4'hE:    n = 8'd72;
         4'h9:    n = 8'd96;
         4'hD:    n = 8'd144;
         4'h8:    n = 8'd192;
         4'hC:    n = 8'd216;
         default: n = 8'd0;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc32_serial                                                             |
// | Bit-serial reflected CRC-32 (poly 0xEDB88320), one data bit per enable.  |
// | Ports: clk_i, rst_i (sync, active-high), init_i (load 0xFFFFFFFF),       |
// |        en_i / d_i (absorb one bit), fcs_o (final complemented CRC).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module crc32_serial
   import ofdm_tx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        init_i,
   input  logic        en_i,
   input  logic        d_i,
   output logic [31:0] fcs_o
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;
   logic        w_fb;

   assign w_fb  = crc_q[0] ^ d_i;
   assign crc_d = w_fb ? ((crc_q >> 1) ^ c_crc_poly) : (crc_q >> 1);

   always_ff @(posedge clk_i) begin
      if (rst_i || init_i) begin
         crc_q <= c_crc_init;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

   assign fcs_o = ~crc_q;

endmodule
`default_nettype wire

// File: rtl/ofdm_tx_bit_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ofdm_tx_bit_framer                                                       |
// | Serialises one legacy OFDM packet: L-SIG (24 bits, clear), SERVICE,      |
// | PSDU, CRC-32 FCS, TAIL and PAD, scrambling the data field.               |
// | Ports: clock/reset; start + pkt_rate/pkt_len/scram_seed request;         |
// |        byte_in/_valid/_ready payload stream; bit_out/_is_sig/_last/      |
// |        _valid/_ready serial output; busy, tx_done, tx_err status.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ofdm_tx_bit_framer
   import ofdm_tx_pkg::*;
#(
   parameter logic [6:0] DEFAULT_SEED = c_scram_default_seed,
   parameter int         LEN_WIDTH    = 12
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           pkt_rate,
   input  logic [LEN_WIDTH-1:0] pkt_len,
   input  logic [6:0]           scram_seed,
   input  logic [7:0]           byte_in,
   input  logic                 byte_in_valid,
   output logic                 byte_in_ready,
   output logic                 bit_out,
   output logic                 bit_out_is_sig,
   output logic                 bit_out_last,
   output logic                 bit_out_valid,
   input  logic                 bit_out_ready,
   output logic                 busy,
   output logic                 tx_done,
   output logic                 tx_err
);

   state_e               state_q;
   logic [7:0]           ndbps_q, dbit_q;
   logic [LEN_WIDTH-1:0] len_q, cnt_q;
   logic [6:0]           scr_q;
   logic [22:0]          sig_sr_q;
   logic [6:0]           sr_q;       // remaining bits of the current byte
   logic [2:0]           sr_cnt_q;   // 0 means empty
   logic                 out_bit_q, out_valid_q, out_sig_q, out_last_q;
   logic                 busy_q, done_q, err_q;

   logic                 w_fb, w_slot_free, w_last_pending;
   logic                 w_have, w_raw, w_out_bit, w_last, w_load;
   logic [6:0]           w_scr_next;
   logic [7:0]           w_dbit_inc, w_start_ndbps;
   logic [11:0]          w_len12;
   logic [23:0]          w_sig_vec;
   logic                 w_start_ok, w_crc_init, w_crc_en;
   logic [31:0]          w_fcs;

   assign w_start_ndbps = rate_to_ndbps(pkt_rate);
   assign w_start_ok    = (w_start_ndbps != 8'd0) && (pkt_len >= LEN_WIDTH'(c_fcs_bytes));
   assign w_len12       = 12'(pkt_len);
   assign w_sig_vec     = {6'b0, ^{w_len12, 1'b0, pkt_rate}, w_len12, 1'b0, pkt_rate};

   assign w_fb       = scr_q[6] ^ scr_q[3];
   assign w_scr_next = {scr_q[5:0], w_fb};
   assign w_dbit_inc = (dbit_q == ndbps_q - 8'd1) ? 8'd0 : dbit_q + 8'd1;

   // The output register can take a new bit when empty or draining this cycle.
   assign w_slot_free    = !out_valid_q || bit_out_ready;
   assign w_last_pending = out_valid_q && out_last_q;

   always_comb begin
      w_have = 1'b1;
      w_raw  = 1'b0;
      case (state_q)
         ST_IDLE: w_have = 1'b0;
         ST_SIG:  w_raw  = sig_sr_q[0];
         ST_PSDU: begin
            w_have = (sr_cnt_q != 3'd0) || byte_in_valid;
            w_raw  = (sr_cnt_q != 3'd0) ? sr_q[0] : byte_in[0];
         end
         ST_FCS:  w_raw  = w_fcs[cnt_q[4:0]];
         default: w_raw  = 1'b0;
      endcase
   end

   assign w_out_bit = (state_q == ST_SIG)  ? w_raw :
                      (state_q == ST_TAIL) ? 1'b0  : (w_raw ^ w_fb);
   assign w_last    = (((state_q == ST_TAIL) && (cnt_q == LEN_WIDTH'(c_tail_bits - 1)))
                       || (state_q == ST_PAD)) && (w_dbit_inc == 8'd0);
   assign w_load    = w_slot_free && w_have && !w_last_pending;

   // A byte is taken only when its first bit goes straight into the output register.
   assign byte_in_ready = (state_q == ST_PSDU) && (sr_cnt_q == 3'd0) && w_slot_free;

   assign w_crc_init = (state_q == ST_IDLE) && start && w_start_ok;
   assign w_crc_en   = w_load && (state_q == ST_PSDU);

   crc32_serial u_crc (
      .clk_i  (clock),
      .rst_i  (reset),
      .init_i (w_crc_init),
      .en_i   (w_crc_en),
      .d_i    (w_raw),
      .fcs_o  (w_fcs)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ndbps_q     <= '0;
         dbit_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         scr_q       <= '0;
         sig_sr_q    <= '0;
         sr_q        <= '0;
         sr_cnt_q    <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sig_q   <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (w_last_pending && bit_out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sig_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0 | 1'b1;
            state_q     <= ST_IDLE;
         end else if (state_q == ST_IDLE) begin
            if (start) begin
               if (!w_start_ok) begin
                  err_q <= 1'b1;
               end else begin
                  // First L-SIG bit is emitted straight from the request.
                  ndbps_q     <= w_start_ndbps;
                  len_q       <= pkt_len;
                  scr_q       <= (scram_seed == 7'd0) ? DEFAULT_SEED : scram_seed;
                  sig_sr_q    <= w_sig_vec[23:1];
                  out_bit_q   <= w_sig_vec[0];
                  out_valid_q <= 1'b1;
                  out_sig_q   <= 1'b1;
                  out_last_q  <= 1'b0;
                  cnt_q       <= LEN_WIDTH'(1);
                  dbit_q      <= '0;
                  sr_cnt_q    <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_SIG;
               end
            end
         end else if (w_load) begin
            out_bit_q   <= w_out_bit;
            out_valid_q <= 1'b1;
            out_sig_q   <= (state_q == ST_SIG);
            out_last_q  <= w_last;
            if (state_q != ST_SIG) begin
               dbit_q <= w_dbit_inc;
               scr_q  <= w_scr_next;
            end
            case (state_q)
               ST_SIG: begin
                  sig_sr_q <= sig_sr_q >> 1;
                  cnt_q    <= cnt_q + LEN_WIDTH'(1);
                  if (cnt_q == LEN_WIDTH'(c_sig_bits - 1)) begin
                     cnt_q   <= '0;
                     state_q <= ST_SERVICE;
                  end
               end
               ST_SERVICE: begin
                  cnt_q <= cnt_q + LEN_WIDTH'(1);
                  if (cnt_q == LEN_WIDTH'(c_service_bits - 1)) begin
                     if (len_q == LEN_WIDTH'(c_fcs_bytes)) begin
                        cnt_q   <= '0;
                        state_q <= ST_FCS;
                     end else begin
                        cnt_q   <= len_q - LEN_WIDTH'(c_fcs_bytes);  // bytes still to fetch
                        state_q <= ST_PSDU;
                     end
                  end
               end
               ST_PSDU: begin
                  if (sr_cnt_q == 3'd0) begin
                     sr_q     <= byte_in[7:1];
                     sr_cnt_q <= 3'd7;
                     cnt_q    <= cnt_q - LEN_WIDTH'(1);
                  end else begin
                     sr_q     <= sr_q >> 1;
                     sr_cnt_q <= sr_cnt_q - 3'd1;
                     if ((sr_cnt_q == 3'd1) && (cnt_q == '0)) begin
                        state_q <= ST_FCS;
                     end
                  end
               end
               ST_FCS: begin
                  cnt_q <= cnt_q + LEN_WIDTH'(1);
                  if (cnt_q == LEN_WIDTH'(c_fcs_bits - 1)) begin
                     cnt_q   <= '0;
                     state_q <= ST_TAIL;
                  end
               end
               ST_TAIL: begin
                  cnt_q <= cnt_q + LEN_WIDTH'(1);
                  if (cnt_q == LEN_WIDTH'(c_tail_bits - 1)) begin
                     state_q <= ST_PAD;
                  end
               end
               default: ;
            endcase
         end else if (w_slot_free) begin
            // Bubble: previous bit drained and nothing new to send.
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sig_q   <= 1'b0;
         end
      end
   end

   assign bit_out        = out_bit_q;
   assign bit_out_valid  = out_valid_q;
   assign bit_out_is_sig = out_sig_q;
   assign bit_out_last   = out_last_q;
   assign busy           = busy_q;
   assign tx_done        = done_q;
   assign tx_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_tx_bit_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ofdm_tx_bit_framer                                                    |
// | Self-checking bench: a reference model fills a queue of expected output  |
// | bits per packet, and each transferred bit is popped and compared.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ofdm_tx_bit_framer;

   logic        clock, reset, start;
   logic [3:0]  pkt_rate;
   logic [11:0] pkt_len;
   logic [6:0]  scram_seed;
   logic [7:0]  byte_in;
   logic        byte_in_valid, byte_in_ready;
   logic        bit_out, bit_out_is_sig, bit_out_last, bit_out_valid, bit_out_ready;
   logic        busy, tx_done, tx_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] exp_q[$];   // {is_sig, last, bit}
   logic [2:0] cap_q[$];
   logic [2:0] t3_cap[$];
   logic [7:0] pay_q[$];
   bit         saw_bready;
   logic [6:0] m_s;
   int         m_tot;

   ofdm_tx_bit_framer #(.DEFAULT_SEED(7'h5D), .LEN_WIDTH(12)) dut (
      .clock(clock), .reset(reset), .start(start), .pkt_rate(pkt_rate),
      .pkt_len(pkt_len), .scram_seed(scram_seed), .byte_in(byte_in),
      .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
      .bit_out(bit_out), .bit_out_is_sig(bit_out_is_sig), .bit_out_last(bit_out_last),
      .bit_out_valid(bit_out_valid), .bit_out_ready(bit_out_ready),
      .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int ref_ndbps(input logic [3:0] r);
      case (r)
         4'hB: return 24;   4'hF: return 36;   4'hA: return 48;   4'hE: return 72;
         4'h9: return 96;   4'hD: return 144;  4'h8: return 192;  4'hC: return 216;
         default: return 0;
      endcase
   endfunction

   task automatic model_bit(input logic d, input bit scr);
      logic fb;
      fb = m_s[6] ^ m_s[3];
      exp_q.push_back({2'b00, scr ? (d ^ fb) : d});
      m_s = {m_s[5:0], fb};
      m_tot++;
   endtask

   task automatic build_model(input logic [3:0] rate, input int len, input logic [6:0] seed);
      logic [11:0] l12;
      logic        par, c;
      logic [31:0] crc;
      logic [7:0]  b;
      logic [2:0]  e;
      int          nd;
      exp_q.delete();
      l12 = len[11:0];
      par = 1'b0;
      for (int i = 0; i < 4; i++) begin exp_q.push_back({2'b10, rate[i]}); par ^= rate[i]; end
      exp_q.push_back(3'b100);
      for (int i = 0; i < 12; i++) begin exp_q.push_back({2'b10, l12[i]}); par ^= l12[i]; end
      exp_q.push_back({2'b10, par});
      for (int i = 0; i < 6; i++) exp_q.push_back(3'b100);
      m_s   = (seed == 7'd0) ? 7'h5D : seed;
      m_tot = 0;
      crc   = 32'hFFFFFFFF;
      nd    = ref_ndbps(rate);
      for (int i = 0; i < 16; i++) model_bit(1'b0, 1'b1);
      for (int j = 0; j < len - 4; j++) begin
         b = pay_q[j];
         for (int i = 0; i < 8; i++) begin
            c   = crc[0] ^ b[i];
            crc = (crc >> 1) ^ (c ? 32'hEDB88320 : 32'h0);
            model_bit(b[i], 1'b1);
         end
      end
      crc = ~crc;
      for (int i = 0; i < 32; i++) model_bit(crc[i], 1'b1);
      for (int i = 0; i < 6; i++) model_bit(1'b0, 1'b0);
      while ((m_tot % nd) != 0) model_bit(1'b0, 1'b1);
      e = exp_q.pop_back();
      e[1] = 1'b1;
      exp_q.push_back(e);
   endtask

   // Runs one packet; abort_at>0 stops driving after that many transferred bits.
   task automatic run_pkt(input logic [3:0] rate, input int len, input logic [6:0] seed,
                          input bit gaps, input int abort_at);
      int cyc, bidx, xfers, last_cyc;
      bit prev_stall, done_seen;
      logic [2:0] prev_out, cur;
      build_model(rate, len, seed);
      cap_q.delete();
      saw_bready = 0; bidx = 0; xfers = 0; last_cyc = -10; prev_stall = 0; done_seen = 0;
      prev_out = '0;
      @(posedge clock); #1;
      start = 1'b1; pkt_rate = rate; pkt_len = len[11:0]; scram_seed = seed;
      bit_out_ready = 1'b1; byte_in_valid = 1'b0;
      for (cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
         @(posedge clock); #1;
         start = gaps && (cyc == 50);
         if (start) begin pkt_rate = 4'h8; pkt_len = 12'd5; end
         bit_out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         byte_in_valid = (bidx < pay_q.size()) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
         byte_in       = (bidx < pay_q.size()) ? pay_q[bidx] : 8'h00;
         @(negedge clock);
         if (cyc == 0) check("start_lat", {busy, bit_out_valid}, 2'b11);
         if (prev_stall)
            check("stall_hold", {bit_out_valid, bit_out_is_sig, bit_out_last, bit_out}, {1'b1, prev_out});
         if (byte_in_ready) saw_bready = 1;
         if (byte_in_valid && byte_in_ready) bidx++;
         if (tx_done) begin
            check("done_lat", cyc, last_cyc + 1);
            check("done_busy", busy, 0);
            done_seen = 1;
         end
         if (bit_out_valid && bit_out_ready) begin
            cur = {bit_out_is_sig, bit_out_last, bit_out};
            cap_q.push_back(cur);
            xfers++;
            if (exp_q.size() == 0) check("extra_bit", 1, 0);
            else check("bit", cur, exp_q.pop_front());
            if (bit_out_last) last_cyc = cyc;
         end
         prev_stall = bit_out_valid && !bit_out_ready;
         prev_out   = {bit_out_is_sig, bit_out_last, bit_out};
         if (abort_at != 0 && xfers >= abort_at) break;
      end
      if (abort_at == 0) begin
         check("done_seen", done_seen, 1);
         check("exp_empty", exp_q.size(), 0);
         @(posedge clock); #1;
         start = 1'b0; bit_out_ready = 1'b1; byte_in_valid = 1'b0;
         @(negedge clock);
         check("done_pulse", {tx_done, busy}, 2'b00);
      end
      start = 1'b0;
   endtask

   task automatic analyze(input logic [6:0] seed, input int fcs_at, output int nsig,
                          output int ndata, output logic [23:0] sig24,
                          output logic [15:0] first16, output logic [31:0] fcs_d);
      logic [6:0] s;
      logic fb;
      s = (seed == 7'd0) ? 7'h5D : seed;
      nsig = 0; ndata = 0; sig24 = '0; first16 = '0; fcs_d = '0;
      foreach (cap_q[i]) begin
         if (cap_q[i][2]) begin
            nsig++;
            sig24 = {sig24[22:0], cap_q[i][0]};
         end else begin
            fb = s[6] ^ s[3];
            if (ndata < 16) first16 = {first16[14:0], cap_q[i][0]};
            if (ndata >= fcs_at && ndata < fcs_at + 32) fcs_d[ndata - fcs_at] = cap_q[i][0] ^ fb;
            s = {s[5:0], fb};
            ndata++;
         end
      end
   endtask

   task automatic err_test(input logic [3:0] rate, input int len);
      @(posedge clock); #1;
      start = 1'b1; pkt_rate = rate; pkt_len = len[11:0];
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      check("err_pulse", {tx_err, busy, bit_out_valid}, 3'b100);
      @(negedge clock);
      check("err_after", {tx_err, busy, bit_out_valid}, 3'b000);
   endtask

   initial begin
      int nsig, ndata, mism;
      logic [23:0] sig24;
      logic [15:0] f16;
      logic [31:0] fcs;
      bit done_during_rst;

      reset = 1'b1; start = 1'b0; pkt_rate = '0; pkt_len = '0; scram_seed = '0;
      byte_in = '0; byte_in_valid = 1'b0; bit_out_ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outs", {bit_out, bit_out_valid, bit_out_is_sig, bit_out_last,
                           busy, tx_done, tx_err, byte_in_ready}, 8'h00);
      @(posedge clock); #1 reset = 1'b0;

      // 6 Mb/s, 100-byte PSDU, all-ones seed
      pay_q.delete();
      for (int i = 0; i < 96; i++) pay_q.push_back(8'(i * 7 + 3));
      run_pkt(4'hB, 100, 7'h7F, 0, 0);
      analyze(7'h7F, 0, nsig, ndata, sig24, f16, fcs);
      check("t1_nsig", nsig, 24);
      check("t1_sig", sig24, 24'hD13000);
      check("t1_first16", f16, 16'b0000111011110010);
      check("t1_ndata", ndata, 840);

      // 54 Mb/s, "123456789", default seed via seed 0; 126 bits before pad -> 90 pad
      pay_q.delete();
      for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
      run_pkt(4'hC, 13, 7'h00, 0, 0);
      analyze(7'h00, 16 + 72, nsig, ndata, sig24, f16, fcs);
      check("t2_fcs", fcs, 32'hCBF43926);
      check("t2_ndata", ndata, 216);

      // FCS-only packet
      pay_q.delete();
      run_pkt(4'hB, 4, 7'h45, 0, 0);
      analyze(7'h45, 0, nsig, ndata, sig24, f16, fcs);
      check("t3_no_bready", saw_bready, 0);
      check("t3_ndata", ndata, 72);
      t3_cap = cap_q;

      // Rejected requests
      err_test(4'h0, 100);
      err_test(4'hB, 3);

      // Random stalls on both sides, plus a start while busy
      pay_q.delete();
      for (int i = 0; i < 196; i++) pay_q.push_back(8'($urandom));
      run_pkt(4'hC, 200, 7'h2A, 1, 0);

      // Reset in the middle of the PSDU
      pay_q.delete();
      for (int i = 0; i < 96; i++) pay_q.push_back(8'(i));
      run_pkt(4'hB, 100, 7'h11, 0, 60);
      @(posedge clock); #1;
      reset = 1'b1; byte_in_valid = 1'b0; start = 1'b0;
      @(negedge clock);
      done_during_rst = tx_done;
      @(negedge clock);
      check("midrst_outs", {bit_out, bit_out_valid, bit_out_is_sig, bit_out_last,
                            busy, tx_done, tx_err, byte_in_ready}, 8'h00);
      @(posedge clock); #1 reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         done_during_rst = done_during_rst | tx_done;
      end
      check("midrst_no_done", done_during_rst, 0);
      pay_q.delete();
      run_pkt(4'hB, 4, 7'h45, 0, 0);
      check("post_rst_len", cap_q.size(), t3_cap.size());
      mism = -1;
      foreach (cap_q[i]) if (i < t3_cap.size() && mism < 0 && cap_q[i] !== t3_cap[i]) mism = i;
      check("post_rst_match", mism, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
